// File: rtl/expr_eval_ctrl.sv
// ---------------------------------------------------------------------------
// expr_eval_ctrl
//
// Purpose:
//   Sequencer/evaluator for a digit-operator character stream such as
//   "3+4*5=". One ASCII character is taken per in_valid/in_ready handshake.
//   The grammar digit ((+|*) digit)* is checked, and the expression is
//   evaluated with '*' binding tighter than '+'. The value, or an error flag,
//   is held on a res_valid/res_ack handshake until the consumer takes it.
//
// Parameters:
//   W       result width in bits; all arithmetic is modulo 2^W
//   MAXLEN  maximum characters per expression, not counting the final '='
//
// Ports:
//   clk        system clock, all logic on posedge
//   clr        synchronous active-high reset, priority over every input
//   in         ASCII character
//   in_valid   character present on in
//   in_ready   block can accept a character this cycle (low only in DONE)
//   result     evaluated value, valid while res_valid=1
//   err        expression malformed, qualified by res_valid
//   res_valid  result/err available (state DONE)
//   res_ack    consumer takes the result
//   busy       expression in progress (OPND, NEXT or ERR)
//   ovf        sticky arithmetic overflow flag, only with EXPR_OVF_EN
//
// Build option:
//   EXPR_OVF_EN  when defined, adds the ovf port and the overflow detection.
//                Without it arithmetic silently wraps modulo 2^W.
// ---------------------------------------------------------------------------
module expr_eval_ctrl #(
    parameter int W      = 16,
    parameter int MAXLEN = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] result,
    output logic         err,
    output logic         res_valid,
    input  logic         res_ack,
    output logic         busy
`ifdef EXPR_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] OPND = 3'd1;
    localparam logic [2:0] NEXT = 3'd2;
    localparam logic [2:0] ERR  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Wide enough to hold the value MAXLEN itself.
    localparam int LW = $clog2(MAXLEN + 1);

    logic [2:0]    state_q,  state_d;
    logic [W-1:0]  sum_q,    sum_d;
    logic [W-1:0]  prod_q,   prod_d;
    logic [LW-1:0] len_q,    len_d;
    logic          op_q,     op_d;
    logic [W-1:0]  result_q, result_d;
    logic          err_q,    err_d;

    logic          accept;
    logic          is_digit;
    logic          is_plus;
    logic          is_star;
    logic          is_eq;
    logic [3:0]    digit;
    logic          len_full;
    logic [W-1:0]  add_res;
    logic [W-1:0]  mul_res;

    // Character classification. The low nibble of '0'..'9' is the digit value.
    assign is_digit = (in >= 8'h30) && (in <= 8'h39);
    assign is_plus  = (in == 8'h2B);
    assign is_star  = (in == 8'h2A);
    assign is_eq    = (in == 8'h3D);
    assign digit    = in[3:0];

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid && in_ready;

    // Another non-'=' byte would push the count past MAXLEN.
    assign len_full = (len_q >= LW'(MAXLEN));

    // The two arithmetic paths, with carry-out kept only when overflow is tracked.
`ifdef EXPR_OVF_EN
    logic          ovf_q, ovf_d;
    logic [W:0]    add_full;
    logic [W+3:0]  mul_full;
    logic          add_carry;
    logic          mul_carry;

    assign add_full  = {1'b0, sum_q} + {1'b0, prod_q};
    assign mul_full  = {4'b0000, prod_q} * {{W{1'b0}}, digit};
    assign add_res   = add_full[W-1:0];
    assign mul_res   = mul_full[W-1:0];
    assign add_carry = add_full[W];
    assign mul_carry = |mul_full[W+3:W];
    assign ovf       = ovf_q;
`else
    assign add_res = sum_q + prod_q;
    assign mul_res = prod_q * W'(digit);
`endif

    // Grammar walk and evaluation. prod holds the running product term and
    // sum the total of completed '+' terms, so '*' binds tighter than '+'.
    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        prod_d   = prod_q;
        len_d    = len_q;
        op_d     = op_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef EXPR_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        prod_d  = W'(digit);
                        sum_d   = '0;
                        len_d   = LW'(1);
                        state_d = OPND;
                    end else if (is_eq) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        len_d   = LW'(1);
                        state_d = ERR;
                    end
                end
            end
            OPND: begin
                if (accept) begin
                    if (is_eq) begin
                        result_d = add_res;
                        err_d    = 1'b0;
`ifdef EXPR_OVF_EN
                        ovf_d    = ovf_q | add_carry;
`endif
                        state_d  = DONE;
                    end else if (len_full) begin
                        state_d = ERR;
                    end else begin
                        len_d = len_q + LW'(1);
                        if (is_plus) begin
                            sum_d   = add_res;
                            op_d    = OP_ADD;
`ifdef EXPR_OVF_EN
                            ovf_d   = ovf_q | add_carry;
`endif
                            state_d = NEXT;
                        end else if (is_star) begin
                            op_d    = OP_MUL;
                            state_d = NEXT;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            NEXT: begin
                if (accept) begin
                    if (is_eq) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else if (len_full) begin
                        state_d = ERR;
                    end else begin
                        len_d = len_q + LW'(1);
                        if (is_digit) begin
                            if (op_q == OP_MUL) begin
                                prod_d = mul_res;
`ifdef EXPR_OVF_EN
                                ovf_d  = ovf_q | mul_carry;
`endif
                            end else begin
                                prod_d = W'(digit);
                            end
                            state_d = OPND;
                        end else begin
                            state_d = ERR;
                        end
                    end
                end
            end
            ERR: begin
                if (accept && is_eq) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (res_ack) begin
`ifdef EXPR_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; clr wins over everything else.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            prod_q   <= '0;
            len_q    <= '0;
            op_q     <= OP_ADD;
            result_q <= '0;
            err_q    <= 1'b0;
`ifdef EXPR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            prod_q   <= prod_d;
            len_q    <= len_d;
            op_q     <= op_d;
            result_q <= result_d;
            err_q    <= err_d;
`ifdef EXPR_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign result    = result_q;
    assign err       = err_q;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q == OPND) || (state_q == NEXT) || (state_q == ERR);

endmodule

// File: tb/tb_expr_eval_ctrl.sv
// ---------------------------------------------------------------------------
// tb_expr_eval_ctrl
//
// Two instances share one input stream: dut_a is narrow and short
// (W=8, MAXLEN=5) to reach wrap and length limits, dut_b uses the defaults
// (W=16, MAXLEN=32). Both accept bytes identically (ERR also consumes bytes
// until '='), so both reach DONE on the same edge.
// Build option EXPR_OVF_EN enables the ovf checks.
// ---------------------------------------------------------------------------
module tb_expr_eval_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  in_ch;
    logic        in_valid;
    logic        res_ack;

    logic        in_ready_a, in_ready_b;
    logic [7:0]  result_a;
    logic [15:0] result_b;
    logic        err_a, err_b;
    logic        res_valid_a, res_valid_b;
    logic        busy_a, busy_b;
`ifdef EXPR_OVF_EN
    logic        ovf_a, ovf_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    expr_eval_ctrl #(.W(8), .MAXLEN(5)) dut_a (
        .clk       (clk),
        .clr       (clr),
        .in        (in_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .result    (result_a),
        .err       (err_a),
        .res_valid (res_valid_a),
        .res_ack   (res_ack),
        .busy      (busy_a)
`ifdef EXPR_OVF_EN
        ,
        .ovf       (ovf_a)
`endif
    );

    expr_eval_ctrl #(.W(16), .MAXLEN(32)) dut_b (
        .clk       (clk),
        .clr       (clr),
        .in        (in_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .result    (result_b),
        .err       (err_b),
        .res_valid (res_valid_b),
        .res_ack   (res_ack),
        .busy      (busy_b)
`ifdef EXPR_OVF_EN
        ,
        .ovf       (ovf_b)
`endif
    );

    // One comparison: count it, report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one byte with in_valid high and wait for the accepting edge.
    task automatic sendByte(input logic [7:0] c);
        int n;
        n        = 0;
        in_ch    = c;
        in_valid = 1'b1;
        while (!in_ready_a && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout got in_ready=0 expected in_ready=1");
        end
        @(posedge clk);
        #1;
    endtask

    // Stream a whole string with in_valid held high, then drop in_valid.
    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            sendByte(s[i]);
        end
        in_valid = 1'b0;
    endtask

    // Pulse res_ack for one edge and confirm the block is back in IDLE.
    task automatic ackResult(input string tag);
        res_ack = 1'b1;
        @(posedge clk);
        #1;
        res_ack = 1'b0;
        checkOutput({tag, "_valid_after_ack"}, {31'd0, res_valid_a}, 32'd0);
        checkOutput({tag, "_ready_after_ack"}, {31'd0, in_ready_a}, 32'd1);
    endtask

    // Send an expression, check both instances the cycle after '=', then ack.
    task automatic runExpr(input string s,
                           input logic [31:0] exp_res_a, input logic exp_err_a,
                           input logic [31:0] exp_res_b, input logic exp_err_b);
        applyStimulus(s);
        checkOutput({s, " valid_a"}, {31'd0, res_valid_a}, 32'd1);
        checkOutput({s, " valid_b"}, {31'd0, res_valid_b}, 32'd1);
        checkOutput({s, " ready_a"}, {31'd0, in_ready_a}, 32'd0);
        checkOutput({s, " result_a"}, {24'd0, result_a}, exp_res_a);
        checkOutput({s, " err_a"}, {31'd0, err_a}, {31'd0, exp_err_a});
        checkOutput({s, " result_b"}, {16'd0, result_b}, exp_res_b);
        checkOutput({s, " err_b"}, {31'd0, err_b}, {31'd0, exp_err_b});
    endtask

    initial begin
        clr      = 1'b1;
        in_ch    = 8'h00;
        in_valid = 1'b0;
        res_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // Reset state.
        checkOutput("rst_valid", {31'd0, res_valid_a}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("rst_ready", {31'd0, in_ready_a}, 32'd1);
        checkOutput("rst_result", {24'd0, result_a}, 32'd0);
        checkOutput("rst_err", {31'd0, err_a}, 32'd0);
`ifdef EXPR_OVF_EN
        checkOutput("rst_ovf", {31'd0, ovf_a}, 32'd0);
`endif

        // Precedence: 3 + (4*5). Check hold without ack first.
        runExpr("3+4*5=", 32'd23, 1'b0, 32'd23, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("hold_valid", {31'd0, res_valid_a}, 32'd1);
        checkOutput("hold_ready", {31'd0, in_ready_a}, 32'd0);
        ackResult("prec");

        // Chain: 7 non-'=' bytes, too long for dut_a.
        runExpr("2*3*4+1=", 32'd0, 1'b1, 32'd25, 1'b0);
        ackResult("chain");
        runExpr("7=", 32'd7, 1'b0, 32'd7, 1'b0);
        ackResult("seven");

        // Syntax errors.
        runExpr("1++2=", 32'd0, 1'b1, 32'd0, 1'b1);
        ackResult("dblop");
        runExpr("+5=", 32'd0, 1'b1, 32'd0, 1'b1);
        ackResult("leadop");
        runExpr("=", 32'd0, 1'b1, 32'd0, 1'b1);
        ackResult("eqonly");
        runExpr("4a=", 32'd0, 1'b1, 32'd0, 1'b1);
        ackResult("illegal");
        runExpr("3*=", 32'd0, 1'b1, 32'd0, 1'b1);
        ackResult("opeq");

        // Wrap: 729 mod 256 = 217 on the 8-bit instance.
        runExpr("9*9*9=", 32'd217, 1'b0, 32'd729, 1'b0);
`ifdef EXPR_OVF_EN
        checkOutput("ovf_set_a", {31'd0, ovf_a}, 32'd1);
        checkOutput("ovf_clear_b", {31'd0, ovf_b}, 32'd0);
`endif
        ackResult("wrap");
        runExpr("2+3=", 32'd5, 1'b0, 32'd5, 1'b0);
`ifdef EXPR_OVF_EN
        checkOutput("ovf_next_a", {31'd0, ovf_a}, 32'd0);
`endif
        ackResult("small");

        // Length: exactly MAXLEN=5 bytes is fine; the 6th non-'=' byte errors.
        runExpr("1+2+3=", 32'd6, 1'b0, 32'd6, 1'b0);
        ackResult("len5");
        runExpr("1+2+3+4=", 32'd0, 1'b1, 32'd10, 1'b0);
        ackResult("len7");

        // Reset mid-expression.
        applyStimulus("8*");
        checkOutput("mid_busy", {31'd0, busy_a}, 32'd1);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_busy", {31'd0, busy_a}, 32'd0);
        checkOutput("clr_ready", {31'd0, in_ready_a}, 32'd1);
        checkOutput("clr_valid", {31'd0, res_valid_a}, 32'd0);
        runExpr("6=", 32'd6, 1'b0, 32'd6, 1'b0);

        // Back-pressure in DONE: a byte offered for 10 cycles is not taken.
        in_ch    = "5";
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("bp_ready", {31'd0, in_ready_a}, 32'd0);
        checkOutput("bp_valid", {31'd0, res_valid_a}, 32'd1);
        checkOutput("bp_result_a", {24'd0, result_a}, 32'd6);
        checkOutput("bp_result_b", {16'd0, result_b}, 32'd6);
        in_valid = 1'b0;
        ackResult("bp");
        runExpr("4*2=", 32'd8, 1'b0, 32'd8, 1'b0);
        ackResult("after_bp");

        // clr while in DONE.
        runExpr("5=", 32'd5, 1'b0, 32'd5, 1'b0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clr_done_valid", {31'd0, res_valid_a}, 32'd0);
        checkOutput("clr_done_result", {24'd0, result_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time guard so the bench cannot hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
